// File: rtl/rs_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : rs_issue_scheduler
// Purpose  : Issue scheduler for a reservation station. Tracks per-slot
//            occupancy, FU assignment and operand readiness, wakes operands
//            from three CDB broadcasts, and each cycle picks the lowest-index
//            ready entry for each of three functional units.
// Ports    : clk, reset (sync, active high), flush
//            alloc_*           : dispatch write into the slot at free_slot
//            free_slot/rs_full : lowest free slot / no free slot (comb)
//            occupancy         : registered valid-entry count
//            cdb_valid_k/tag_k : wakeup broadcasts, k = 0..2
//            fu_stall_k        : FU k cannot accept this cycle
//            issue_valid_k/slot_k : registered issue strobe and slot index
// Revision : 1.0 - initial release
// ============================================================================
module rs_issue_scheduler #(
    parameter int RS_SIZE = 64,
    parameter int IDX_W   = 6,
    parameter int TAG_W   = 6,
    parameter int NUM_FU  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             alloc_valid,
    input  logic [1:0]       alloc_fu,
    input  logic [TAG_W-1:0] alloc_rs1_tag,
    input  logic             alloc_rs1_ready,
    input  logic [TAG_W-1:0] alloc_rs2_tag,
    input  logic             alloc_rs2_ready,
    output logic [IDX_W-1:0] free_slot,
    output logic             rs_full,
    output logic [IDX_W:0]   occupancy,
    input  logic             cdb_valid_0,
    input  logic [TAG_W-1:0] cdb_tag_0,
    input  logic             cdb_valid_1,
    input  logic [TAG_W-1:0] cdb_tag_1,
    input  logic             cdb_valid_2,
    input  logic [TAG_W-1:0] cdb_tag_2,
    input  logic             fu_stall_0,
    input  logic             fu_stall_1,
    input  logic             fu_stall_2,
    output logic             issue_valid_0,
    output logic [IDX_W-1:0] issue_slot_0,
    output logic             issue_valid_1,
    output logic [IDX_W-1:0] issue_slot_1,
    output logic             issue_valid_2,
    output logic [IDX_W-1:0] issue_slot_2
);

    localparam logic [IDX_W:0] c_full_count = (IDX_W+1)'(RS_SIZE);

    // Per-slot state
    logic [RS_SIZE-1:0] r_valid;
    logic [RS_SIZE-1:0] r_rs1_rdy;
    logic [RS_SIZE-1:0] r_rs2_rdy;
    logic [1:0]         r_fu      [RS_SIZE];
    logic [TAG_W-1:0]   r_rs1_tag [RS_SIZE];
    logic [TAG_W-1:0]   r_rs2_tag [RS_SIZE];

    logic [IDX_W:0]     r_occupancy;
    logic [NUM_FU-1:0]  r_issue_valid;
    logic [IDX_W-1:0]   r_issue_slot [NUM_FU];

    // Per-port views of the scalar CDB / stall ports
    logic [NUM_FU-1:0]  w_cdb_valid;
    logic [TAG_W-1:0]   w_cdb_tag [NUM_FU];
    logic [NUM_FU-1:0]  w_fu_stall;

    assign w_cdb_valid  = {cdb_valid_2, cdb_valid_1, cdb_valid_0};
    assign w_cdb_tag[0] = cdb_tag_0;
    assign w_cdb_tag[1] = cdb_tag_1;
    assign w_cdb_tag[2] = cdb_tag_2;
    assign w_fu_stall   = {fu_stall_2, fu_stall_1, fu_stall_0};

    // Lowest free slot; falls back to RS_SIZE-1 when full (don't-care then)
    logic [IDX_W-1:0] w_free_slot;
    always_comb begin
        w_free_slot = IDX_W'(RS_SIZE - 1);
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!r_valid[i]) w_free_slot = IDX_W'(i);
        end
    end

    logic w_rs_full;
    assign w_rs_full = (r_occupancy == c_full_count);

    logic w_alloc_accept;
    assign w_alloc_accept = alloc_valid && !w_rs_full && !flush && (alloc_fu != 2'd3);

    // Tag match of every stored operand and of the incoming operands against
    // all three broadcasts in parallel
    logic [RS_SIZE-1:0] w_rs1_hit;
    logic [RS_SIZE-1:0] w_rs2_hit;
    logic               w_alloc_rs1_hit;
    logic               w_alloc_rs2_hit;
    always_comb begin
        w_rs1_hit       = '0;
        w_rs2_hit       = '0;
        w_alloc_rs1_hit = 1'b0;
        w_alloc_rs2_hit = 1'b0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (w_cdb_valid[k]) begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (r_rs1_tag[i] == w_cdb_tag[k]) w_rs1_hit[i] = 1'b1;
                    if (r_rs2_tag[i] == w_cdb_tag[k]) w_rs2_hit[i] = 1'b1;
                end
                if (alloc_rs1_tag == w_cdb_tag[k]) w_alloc_rs1_hit = 1'b1;
                if (alloc_rs2_tag == w_cdb_tag[k]) w_alloc_rs2_hit = 1'b1;
            end
        end
    end

    // Tag 0 is the hardwired zero register and never waits
    logic w_alloc_rs1_rdy;
    logic w_alloc_rs2_rdy;
    assign w_alloc_rs1_rdy = alloc_rs1_ready || (alloc_rs1_tag == '0) || w_alloc_rs1_hit;
    assign w_alloc_rs2_rdy = alloc_rs2_ready || (alloc_rs2_tag == '0) || w_alloc_rs2_hit;

    // Selection uses pre-edge readiness only, so a wakeup this cycle is
    // visible to select one cycle later
    logic [RS_SIZE-1:0] w_ready;
    assign w_ready = r_valid & r_rs1_rdy & r_rs2_rdy;

    logic [NUM_FU-1:0] w_sel_found;
    logic [IDX_W-1:0]  w_sel_idx [NUM_FU];
    logic [NUM_FU-1:0] w_issue;
    always_comb begin
        for (int k = 0; k < NUM_FU; k++) begin
            w_sel_found[k] = 1'b0;
            w_sel_idx[k]   = '0;
            for (int i = RS_SIZE - 1; i >= 0; i--) begin
                if (w_ready[i] && (r_fu[i] == 2'(k))) begin
                    w_sel_found[k] = 1'b1;
                    w_sel_idx[k]   = IDX_W'(i);
                end
            end
        end
        w_issue = w_sel_found & ~w_fu_stall;
    end

    logic [RS_SIZE-1:0] w_clear;
    logic [IDX_W:0]     w_issue_cnt;
    always_comb begin
        w_clear     = '0;
        w_issue_cnt = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (w_issue[k]) begin
                w_clear[w_sel_idx[k]] = 1'b1;
                w_issue_cnt           = w_issue_cnt + (IDX_W+1)'(1);
            end
        end
    end

    // Control state: valid bits, occupancy, issue outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid       <= '0;
            r_occupancy   <= '0;
            r_issue_valid <= '0;
            for (int k = 0; k < NUM_FU; k++) r_issue_slot[k] <= '0;
        end else if (flush) begin
            r_valid       <= '0;
            r_occupancy   <= '0;
            r_issue_valid <= '0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (w_clear[i]) begin
                    r_valid[i] <= 1'b0;
                end else if (w_alloc_accept && (w_free_slot == IDX_W'(i))) begin
                    r_valid[i] <= 1'b1;
                end
            end
            r_occupancy   <= r_occupancy + (IDX_W+1)'(w_alloc_accept) - w_issue_cnt;
            r_issue_valid <= w_issue;
            for (int k = 0; k < NUM_FU; k++) begin
                if (w_issue[k]) r_issue_slot[k] <= w_sel_idx[k];
            end
        end
    end

    // Payload: qualified by r_valid, so it needs no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < RS_SIZE; i++) begin
            if (w_alloc_accept && (w_free_slot == IDX_W'(i))) begin
                r_fu[i]      <= alloc_fu;
                r_rs1_tag[i] <= alloc_rs1_tag;
                r_rs2_tag[i] <= alloc_rs2_tag;
                r_rs1_rdy[i] <= w_alloc_rs1_rdy;
                r_rs2_rdy[i] <= w_alloc_rs2_rdy;
            end else begin
                if (w_rs1_hit[i]) r_rs1_rdy[i] <= 1'b1;
                if (w_rs2_hit[i]) r_rs2_rdy[i] <= 1'b1;
            end
        end
    end

    assign free_slot     = w_free_slot;
    assign rs_full       = w_rs_full;
    assign occupancy     = r_occupancy;
    assign issue_valid_0 = r_issue_valid[0];
    assign issue_valid_1 = r_issue_valid[1];
    assign issue_valid_2 = r_issue_valid[2];
    assign issue_slot_0  = r_issue_slot[0];
    assign issue_slot_1  = r_issue_slot[1];
    assign issue_slot_2  = r_issue_slot[2];

endmodule
`default_nettype wire

// File: tb/tb_rs_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs_issue_scheduler
// Purpose  : Self-checking bench for rs_issue_scheduler: directed vector
//            table, hand-written multi-cycle sequences and random traffic,
//            all checked against an entry-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rs_issue_scheduler;

    typedef struct {
        logic       av;
        logic [1:0] fu;
        logic [5:0] t1;
        logic       r1;
        logic [5:0] t2;
        logic       r2;
        logic [2:0] cv;
        logic [5:0] ct0, ct1, ct2;
        logic [2:0] stall;
        logic       fl;
        logic       rs;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic [2:0] iv;
        logic [5:0] s0, s1, s2;
        logic [6:0] occ;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset, flush, alloc_valid;
    logic [1:0] alloc_fu;
    logic [5:0] alloc_rs1_tag, alloc_rs2_tag;
    logic       alloc_rs1_ready, alloc_rs2_ready;
    logic [5:0] free_slot;
    logic       rs_full;
    logic [6:0] occupancy;
    logic       cdb_valid_0, cdb_valid_1, cdb_valid_2;
    logic [5:0] cdb_tag_0, cdb_tag_1, cdb_tag_2;
    logic       fu_stall_0, fu_stall_1, fu_stall_2;
    logic       issue_valid_0, issue_valid_1, issue_valid_2;
    logic [5:0] issue_slot_0, issue_slot_1, issue_slot_2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rs_issue_scheduler dut (
        .clk(clk), .reset(reset), .flush(flush), .alloc_valid(alloc_valid),
        .alloc_fu(alloc_fu), .alloc_rs1_tag(alloc_rs1_tag), .alloc_rs1_ready(alloc_rs1_ready),
        .alloc_rs2_tag(alloc_rs2_tag), .alloc_rs2_ready(alloc_rs2_ready),
        .free_slot(free_slot), .rs_full(rs_full), .occupancy(occupancy),
        .cdb_valid_0(cdb_valid_0), .cdb_tag_0(cdb_tag_0),
        .cdb_valid_1(cdb_valid_1), .cdb_tag_1(cdb_tag_1),
        .cdb_valid_2(cdb_valid_2), .cdb_tag_2(cdb_tag_2),
        .fu_stall_0(fu_stall_0), .fu_stall_1(fu_stall_1), .fu_stall_2(fu_stall_2),
        .issue_valid_0(issue_valid_0), .issue_slot_0(issue_slot_0),
        .issue_valid_1(issue_valid_1), .issue_slot_1(issue_slot_1),
        .issue_valid_2(issue_valid_2), .issue_slot_2(issue_slot_2)
    );

    // ---------------- reference model: a plain list of 64 entries ----------
    bit         m_valid [64];
    logic [1:0] m_fu    [64];
    logic [5:0] m_t1    [64];
    logic [5:0] m_t2    [64];
    bit         m_r1    [64];
    bit         m_r2    [64];
    logic [2:0] m_iv;
    logic [5:0] m_is    [3];
    bit         m_init = 1'b0;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 64; i++) n += int'(m_valid[i]);
        return n;
    endfunction

    function automatic int m_free();
        for (int i = 0; i < 64; i++) if (!m_valid[i]) return i;
        return 63;
    endfunction

    function automatic bit m_hit(input stim_t s, input logic [5:0] tag);
        return (s.cv[0] && s.ct0 == tag) || (s.cv[1] && s.ct1 == tag) ||
               (s.cv[2] && s.ct2 == tag);
    endfunction

    task automatic m_step(input stim_t s);
        int pick [3];
        int fs;
        bit acc;
        if (s.rs) begin
            for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
            m_iv = 3'b000;
            for (int k = 0; k < 3; k++) m_is[k] = 6'd0;
            m_init = 1'b1;
        end else if (s.fl) begin
            for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
            m_iv = 3'b000;
        end else begin
            for (int k = 0; k < 3; k++) begin
                pick[k] = -1;
                if (!s.stall[k]) begin
                    for (int i = 0; i < 64; i++) begin
                        if (m_valid[i] && m_r1[i] && m_r2[i] && m_fu[i] == 2'(k)) begin
                            pick[k] = i;
                            break;
                        end
                    end
                end
            end
            acc = s.av && (m_count() < 64) && (s.fu != 2'd3);
            fs  = m_free();
            for (int i = 0; i < 64; i++) begin
                if (m_valid[i]) begin
                    if (m_hit(s, m_t1[i])) m_r1[i] = 1'b1;
                    if (m_hit(s, m_t2[i])) m_r2[i] = 1'b1;
                end
            end
            for (int k = 0; k < 3; k++) begin
                if (pick[k] >= 0) begin
                    m_valid[pick[k]] = 1'b0;
                    m_iv[k] = 1'b1;
                    m_is[k] = 6'(pick[k]);
                end else begin
                    m_iv[k] = 1'b0;
                end
            end
            if (acc) begin
                m_valid[fs] = 1'b1;
                m_fu[fs] = s.fu;
                m_t1[fs] = s.t1;
                m_t2[fs] = s.t2;
                m_r1[fs] = s.r1 || (s.t1 == 6'd0) || m_hit(s, s.t1);
                m_r2[fs] = s.r2 || (s.t2 == 6'd0) || m_hit(s, s.t2);
            end
        end
    endtask

    // ---------------- helpers ----------------------------------------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic stim_t st(input logic av, input logic [1:0] fu,
                                 input logic [5:0] t1, input logic r1,
                                 input logic [5:0] t2, input logic r2,
                                 input logic [2:0] cv, input logic [5:0] ct0,
                                 input logic [5:0] ct1, input logic [5:0] ct2,
                                 input logic [2:0] stall, input logic fl, input logic rs);
        stim_t s;
        s.av = av; s.fu = fu; s.t1 = t1; s.r1 = r1; s.t2 = t2; s.r2 = r2;
        s.cv = cv; s.ct0 = ct0; s.ct1 = ct1; s.ct2 = ct2;
        s.stall = stall; s.fl = fl; s.rs = rs;
        return s;
    endfunction

    function automatic stim_t idle();
        return st(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b000, 0, 0);
    endfunction

    // One cycle: drive at negedge, check combinational outputs, advance model,
    // then check registered outputs 1 time unit after the rising edge.
    task automatic step(input stim_t s);
        @(negedge clk);
        reset = s.rs; flush = s.fl; alloc_valid = s.av; alloc_fu = s.fu;
        alloc_rs1_tag = s.t1; alloc_rs1_ready = s.r1;
        alloc_rs2_tag = s.t2; alloc_rs2_ready = s.r2;
        cdb_valid_0 = s.cv[0]; cdb_valid_1 = s.cv[1]; cdb_valid_2 = s.cv[2];
        cdb_tag_0 = s.ct0; cdb_tag_1 = s.ct1; cdb_tag_2 = s.ct2;
        fu_stall_0 = s.stall[0]; fu_stall_1 = s.stall[1]; fu_stall_2 = s.stall[2];
        #1;
        if (m_init) begin
            chk("rs_full", 32'(rs_full), 32'(m_count() == 64));
            if (m_count() < 64) chk("free_slot", 32'(free_slot), 32'(m_free()));
        end
        m_step(s);
        @(posedge clk);
        #1;
        chk("occupancy", 32'(occupancy), 32'(m_count()));
        chk("issue_valid", 32'({issue_valid_2, issue_valid_1, issue_valid_0}), 32'(m_iv));
        chk("issue_slot_0", 32'(issue_slot_0), 32'(m_is[0]));
        chk("issue_slot_1", 32'(issue_slot_1), 32'(m_is[1]));
        chk("issue_slot_2", 32'(issue_slot_2), 32'(m_is[2]));
    endtask

    function automatic stim_t rnd();
        stim_t s;
        s.av  = ($urandom_range(0, 9) < 6);
        s.fu  = 2'($urandom_range(0, 3));
        s.t1  = 6'($urandom_range(0, 15));
        s.r1  = ($urandom_range(0, 9) < 3);
        s.t2  = 6'($urandom_range(0, 15));
        s.r2  = ($urandom_range(0, 9) < 3);
        s.cv  = {($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 4)};
        s.ct0 = 6'($urandom_range(0, 15));
        s.ct1 = 6'($urandom_range(0, 15));
        s.ct2 = 6'($urandom_range(0, 15));
        s.stall = {($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 2)};
        s.fl  = ($urandom_range(0, 99) < 2);
        s.rs  = ($urandom_range(0, 199) < 1);
        return s;
    endfunction

    vec_t tbl [$];

    initial begin
        vec_t v;
        stim_t s;

        // ---------- directed table ----------
        // reset
        v.s = st(0,0,0,0,0,0,3'b000,0,0,0,3'b000,0,1); v.iv=3'b000; v.s0=0; v.s1=0; v.s2=0; v.occ=0; tbl.push_back(v);
        // three ready allocations to FU0/1/2 while all FUs stall -> slots 0/1/2
        v.s = st(1,0,1,1,2,1,3'b000,0,0,0,3'b111,0,0); v.iv=3'b000; v.occ=1; tbl.push_back(v);
        v.s = st(1,1,1,1,2,1,3'b000,0,0,0,3'b111,0,0); v.iv=3'b000; v.occ=2; tbl.push_back(v);
        v.s = st(1,2,1,1,2,1,3'b000,0,0,0,3'b111,0,0); v.iv=3'b000; v.occ=3; tbl.push_back(v);
        v.s = idle(); v.iv=3'b111; v.s0=0; v.s1=1; v.s2=2; v.occ=0; tbl.push_back(v);
        v.s = idle(); v.iv=3'b000; v.occ=0; tbl.push_back(v);
        // FU1 entry waiting on tag 5, rs2 is x0
        v.s = st(1,1,5,0,0,0,3'b000,0,0,0,3'b000,0,0); v.iv=3'b000; v.occ=1; tbl.push_back(v);
        for (int i = 0; i < 4; i++) begin
            v.s = idle(); v.iv=3'b000; v.occ=1; tbl.push_back(v);
        end
        v.s = st(0,0,0,0,0,0,3'b100,0,0,5,3'b000,0,0); v.iv=3'b000; v.occ=1; tbl.push_back(v);
        v.s = idle(); v.iv=3'b010; v.s1=0; v.occ=0; tbl.push_back(v);
        // same-cycle wakeup on rs2 via CDB0
        v.s = st(1,0,3,1,9,0,3'b001,9,0,0,3'b000,0,0); v.iv=3'b000; v.occ=1; tbl.push_back(v);
        v.s = idle(); v.iv=3'b001; v.s0=0; v.occ=0; tbl.push_back(v);
        // illegal FU 3 is dropped
        v.s = st(1,3,0,1,0,1,3'b000,0,0,0,3'b000,0,0); v.iv=3'b000; v.occ=0; tbl.push_back(v);
        v.s = idle(); v.iv=3'b000; v.occ=0; tbl.push_back(v);

        foreach (tbl[i]) begin
            step(tbl[i].s);
            chk("tbl_iv",  32'({issue_valid_2, issue_valid_1, issue_valid_0}), 32'(tbl[i].iv));
            chk("tbl_s0",  32'(issue_slot_0), 32'(tbl[i].s0));
            chk("tbl_s1",  32'(issue_slot_1), 32'(tbl[i].s1));
            chk("tbl_s2",  32'(issue_slot_2), 32'(tbl[i].s2));
            chk("tbl_occ", 32'(occupancy), 32'(tbl[i].occ));
        end

        // ---------- stall: ready FU0 entries in slots 3 and 7 ----------
        step(st(0,0,0,0,0,0,3'b000,0,0,0,3'b000,0,1));
        for (int i = 0; i < 8; i++) begin
            if (i == 3 || i == 7) step(st(1,0,1,1,1,1,3'b000,0,0,0,3'b001,0,0));
            else                  step(st(1,2,20,0,1,1,3'b000,0,0,0,3'b001,0,0));
        end
        for (int i = 0; i < 2; i++) begin
            step(st(0,0,0,0,0,0,3'b000,0,0,0,3'b001,0,0));
            chk("stall_no_issue", 32'(issue_valid_0), 32'(0));
        end
        step(idle());
        chk("stall_rel_v", 32'(issue_valid_0), 32'(1));
        chk("stall_rel_s", 32'(issue_slot_0), 32'(3));
        step(idle());
        chk("stall_2nd_v", 32'(issue_valid_0), 32'(1));
        chk("stall_2nd_s", 32'(issue_slot_0), 32'(7));
        chk("stall_occ",   32'(occupancy), 32'(6));
        step(idle());
        chk("stall_done",  32'(issue_valid_0), 32'(0));

        // ---------- fill all 64, none ready ----------
        step(st(0,0,0,0,0,0,3'b000,0,0,0,3'b000,0,1));
        for (int i = 0; i < 64; i++)
            step(st(1, 2'(i % 3), (i == 10) ? 6'd50 : 6'd33, 0, 1, 1, 3'b000, 0, 0, 0, 3'b000, 0, 0));
        #1;
        chk("full_flag", 32'(rs_full), 32'(1));
        chk("full_occ",  32'(occupancy), 32'(64));
        step(st(1,0,0,1,0,1,3'b000,0,0,0,3'b000,0,0));
        chk("full_drop_occ", 32'(occupancy), 32'(64));
        step(st(0,0,0,0,0,0,3'b001,50,0,0,3'b000,0,0));
        chk("wake_no_issue_yet", 32'(issue_valid_1), 32'(0));
        step(idle());
        chk("wake_iv1",   32'(issue_valid_1), 32'(1));
        chk("wake_slot1", 32'(issue_slot_1), 32'(10));
        chk("wake_occ",   32'(occupancy), 32'(63));
        chk("after_full", 32'(rs_full), 32'(0));
        chk("after_free", 32'(free_slot), 32'(10));

        // ---------- flush / reset mid-fill with concurrent alloc ----------
        for (int pass = 0; pass < 2; pass++) begin
            step(st(0,0,0,0,0,0,3'b000,0,0,0,3'b000,0,1));
            step(st(1,0,1,1,1,1,3'b000,0,0,0,3'b001,0,0));
            for (int i = 1; i < 20; i++) step(st(1,1,33,0,1,1,3'b000,0,0,0,3'b001,0,0));
            chk("pre_flush_occ", 32'(occupancy), 32'(20));
            step(st(1,0,1,1,1,1,3'b000,0,0,0,3'b000, pass == 0, pass == 1));
            chk("flush_occ",  32'(occupancy), 32'(0));
            chk("flush_iv",   32'({issue_valid_2, issue_valid_1, issue_valid_0}), 32'(0));
            chk("flush_free", 32'(free_slot), 32'(0));
            chk("flush_full", 32'(rs_full), 32'(0));
        end

        // ---------- random traffic against the model ----------
        for (int n = 0; n < 1500; n++) begin
            s = rnd();
            step(s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
